// File: rtl/cart_bus_ctrl_if.sv
// Cartridge bus controller signal bundle: two requester handshakes plus the
// cartridge-edge CPU bus pins. The controller takes the slave view; the
// requesters and pin drivers take the master view.
interface cart_bus_ctrl_if;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        dbg_req;
  logic [15:0] dbg_addr;
  logic        dbg_rw;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;

  logic [14:0] bus_a;
  logic        bus_rw;
  logic        bus_m2;
  logic        bus_romsel_n;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_addr, cpu_rw, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_addr, dbg_rw, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output bus_a, bus_rw, bus_m2, bus_romsel_n, bus_d_out, bus_d_oe,
    input  bus_d_in,
    output busy
  );

  modport master (
    output cpu_req, cpu_addr, cpu_rw, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_addr, dbg_rw, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  bus_a, bus_rw, bus_m2, bus_romsel_n, bus_d_out, bus_d_oe,
    output bus_d_in,
    input  busy
  );
endinterface

// File: rtl/cart_bus_ctrl.sv
// Cartridge-edge CPU bus sequencer. Arbitrates round-robin between the CPU
// core and a debug/dump engine, then runs one timed bus cycle per grant:
// SETUP (address/RW valid), ACTIVE (M2 high), HOLD, and a one-cycle DONE ack.
// All bus pins are registered and change together with the state register.
module cart_bus_ctrl #(
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned ACTIVE_CYC = 12,
  parameter int unsigned HOLD_CYC   = 3,
  parameter int unsigned CNT_W      = 5
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  cart_bus_ctrl_if.slave   bif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] L_SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_ACTIVE_LAST = CNT_W'(ACTIVE_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_dbg;
  logic             r_gnt_dbg;
  logic             r_a15;
  logic             r_rw;
  logic [7:0]       r_wdata;
  logic [7:0]       r_cap;
  logic [14:0]      r_bus_a;
  logic             r_bus_rw;
  logic             r_bus_m2;
  logic             r_romsel_n;
  logic [7:0]       r_d_out;
  logic             r_d_oe;
  logic             r_cpu_ack;
  logic             r_dbg_ack;
  logic [7:0]       r_cpu_rdata;
  logic [7:0]       r_dbg_rdata;

  logic             w_any_req;
  logic             w_gnt_dbg;
  logic [15:0]      w_addr;
  logic             w_rw;
  logic [7:0]       w_wdata;

  // Round-robin pick: debug wins only if it is alone or the CPU went last.
  always_comb begin
    w_any_req = bif.cpu_req | bif.dbg_req;
    w_gnt_dbg = bif.dbg_req & (~bif.cpu_req | ~r_last_dbg);
    w_addr    = w_gnt_dbg ? bif.dbg_addr  : bif.cpu_addr;
    w_rw      = w_gnt_dbg ? bif.dbg_rw    : bif.cpu_rw;
    w_wdata   = w_gnt_dbg ? bif.dbg_wdata : bif.cpu_wdata;
  end

  // Bus-cycle sequencer; pin registers are updated on each state transition
  // so every pin value lines up with the state it belongs to.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_dbg  <= 1'b1;
      r_gnt_dbg   <= 1'b0;
      r_a15       <= 1'b0;
      r_rw        <= 1'b1;
      r_wdata     <= '0;
      r_cap       <= '0;
      r_bus_a     <= '0;
      r_bus_rw    <= 1'b1;
      r_bus_m2    <= 1'b0;
      r_romsel_n  <= 1'b1;
      r_d_out     <= '0;
      r_d_oe      <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_dbg  <= w_gnt_dbg;
            r_last_dbg <= w_gnt_dbg;
            r_a15      <= w_addr[15];
            r_rw       <= w_rw;
            r_wdata    <= w_wdata;
            r_bus_a    <= w_addr[14:0];
            r_bus_rw   <= w_rw;
            r_cnt      <= '0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == L_SETUP_LAST) begin
            r_cnt      <= '0;
            r_state    <= S_ACTIVE;
            r_bus_m2   <= 1'b1;
            r_romsel_n <= ~r_a15;
            r_d_oe     <= ~r_rw;
            if (!r_rw) r_d_out <= r_wdata;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACTIVE: begin
          if (r_cnt == L_ACTIVE_LAST) begin
            if (r_rw) r_cap <= bif.bus_d_in;
            r_cnt      <= '0;
            r_state    <= S_HOLD;
            r_bus_m2   <= 1'b0;
            r_romsel_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == L_HOLD_LAST) begin
            r_cnt     <= '0;
            r_state   <= S_DONE;
            r_bus_rw  <= 1'b1;
            r_d_oe    <= 1'b0;
            r_cpu_ack <= ~r_gnt_dbg;
            r_dbg_ack <= r_gnt_dbg;
            if (r_rw) begin
              if (r_gnt_dbg) r_dbg_rdata <= r_cap;
              else           r_cpu_rdata <= r_cap;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.bus_a        = r_bus_a;
  assign bif.bus_rw       = r_bus_rw;
  assign bif.bus_m2       = r_bus_m2;
  assign bif.bus_romsel_n = r_romsel_n;
  assign bif.bus_d_out    = r_d_out;
  assign bif.bus_d_oe     = r_d_oe;
  assign bif.cpu_ack      = r_cpu_ack;
  assign bif.dbg_ack      = r_dbg_ack;
  assign bif.cpu_rdata    = r_cpu_rdata;
  assign bif.dbg_rdata    = r_dbg_rdata;
  assign bif.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Directed bench for cart_bus_ctrl: default-timing instance plus a
// short-timing instance (1/2/1) sharing clock and reset.
module tb_cart_bus_ctrl;
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  cart_bus_ctrl_if bif();
  cart_bus_ctrl_if bif2();

  cart_bus_ctrl dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bif      (bif)
  );

  cart_bus_ctrl #(
    .SETUP_CYC  (1),
    .ACTIVE_CYC (2),
    .HOLD_CYC   (1),
    .CNT_W      (2)
  ) dut_s (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bif      (bif2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  // Steps one cycle at a time until an ack appears, counting pin behaviour.
  // Read data is presented on bus_d_in only while M2 is high.
  task automatic watch(input int max_cyc, input logic [7:0] rd_val, input logic [7:0] exp_dout,
                       output int ack_cyc, output int ack_who, output int romsel_lo,
                       output int rw_lo, output int oe_hi, output int bad_dout, output int bad_romsel);
    ack_cyc = 0; ack_who = 0; romsel_lo = 0; rw_lo = 0; oe_hi = 0; bad_dout = 0; bad_romsel = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge CLOCK_50); #1;
      if (!bif.bus_romsel_n) romsel_lo++;
      if (!bif.bus_romsel_n && !bif.bus_m2) bad_romsel++;
      if (!bif.bus_rw) rw_lo++;
      if (bif.bus_d_oe) begin
        oe_hi++;
        if (bif.bus_d_out !== exp_dout) bad_dout++;
      end
      bif.bus_d_in = bif.bus_m2 ? rd_val : 8'h00;
      if (bif.cpu_ack || bif.dbg_ack) begin
        ack_cyc = n + 1;
        ack_who = {30'd0, bif.dbg_ack, bif.cpu_ack};
        break;
      end
    end
  endtask

  task automatic test_reset;
    bif.cpu_req = 0; bif.cpu_addr = '0; bif.cpu_rw = 1; bif.cpu_wdata = '0;
    bif.dbg_req = 0; bif.dbg_addr = '0; bif.dbg_rw = 1; bif.dbg_wdata = '0;
    bif.bus_d_in = '0;
    bif2.cpu_req = 0; bif2.cpu_addr = '0; bif2.cpu_rw = 1; bif2.cpu_wdata = '0;
    bif2.dbg_req = 0; bif2.dbg_addr = '0; bif2.dbg_rw = 1; bif2.dbg_wdata = '0;
    bif2.bus_d_in = '0;
    reset = 1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    checks++;
    if ({bif.bus_a, bif.bus_rw, bif.bus_m2, bif.bus_romsel_n, bif.bus_d_out, bif.bus_d_oe,
         bif.cpu_ack, bif.dbg_ack, bif.busy} !== {15'h0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_pins: got a=%h rw=%b m2=%b rs=%b do=%h oe=%b ack=%b%b busy=%b, expected a=0 rw=1 m2=0 rs=1 do=0 oe=0 ack=00 busy=0",
               bif.bus_a, bif.bus_rw, bif.bus_m2, bif.bus_romsel_n, bif.bus_d_out, bif.bus_d_oe,
               bif.cpu_ack, bif.dbg_ack, bif.busy);
    end
    checks++;
    if ({bif.cpu_rdata, bif.dbg_rdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got %h, expected 0000", {bif.cpu_rdata, bif.dbg_rdata});
    end
    reset = 0;
    @(posedge CLOCK_50); #1;
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req_busy: got %b, expected 0", bif.busy);
    end
  endtask

  task automatic test_cpu_read;
    int ac, who, rl, wl, oe, bd, br;
    bif.cpu_addr = 16'h8003; bif.cpu_rw = 1; bif.cpu_req = 1;
    watch(40, 8'hA5, 8'h00, ac, who, rl, wl, oe, bd, br);
    bif.cpu_req = 0;
    checks++; if (ac !== 20) begin errors++; $display("FAIL rd_latency: got %0d, expected 20", ac); end
    checks++; if (who !== 1) begin errors++; $display("FAIL rd_ack_who: got %0d, expected 1", who); end
    checks++; if (rl !== 12) begin errors++; $display("FAIL rd_romsel_cycles: got %0d, expected 12", rl); end
    checks++; if (br !== 0) begin errors++; $display("FAIL rd_romsel_without_m2: got %0d, expected 0", br); end
    checks++; if ((wl + oe) !== 0) begin errors++; $display("FAIL rd_rw_oe: got %0d, expected 0", wl + oe); end
    checks++; if (bif.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_cpu_rdata: got %h, expected a5", bif.cpu_rdata); end
    checks++; if (bif.bus_a !== 15'h0003) begin errors++; $display("FAIL rd_bus_a: got %h, expected 0003", bif.bus_a); end
    @(posedge CLOCK_50); #1;
    checks++;
    if ({bif.cpu_ack, bif.dbg_ack, bif.busy} !== 3'b000) begin
      errors++;
      $display("FAIL rd_ack_pulse: got %b, expected 000", {bif.cpu_ack, bif.dbg_ack, bif.busy});
    end
    checks++; if (bif.dbg_rdata !== 8'h00) begin errors++; $display("FAIL rd_dbg_rdata: got %h, expected 00", bif.dbg_rdata); end
  endtask

  task automatic test_cpu_write;
    int ac, who, rl, wl, oe, bd, br;
    bif.cpu_addr = 16'h6000; bif.cpu_rw = 0; bif.cpu_wdata = 8'h3C; bif.cpu_req = 1;
    watch(40, 8'hEE, 8'h3C, ac, who, rl, wl, oe, bd, br);
    bif.cpu_req = 0;
    checks++; if (ac !== 20) begin errors++; $display("FAIL wr_latency: got %0d, expected 20", ac); end
    checks++; if (who !== 1) begin errors++; $display("FAIL wr_ack_who: got %0d, expected 1", who); end
    checks++; if (wl !== 18) begin errors++; $display("FAIL wr_rw_low: got %0d, expected 18", wl); end
    checks++; if (oe !== 15) begin errors++; $display("FAIL wr_oe_high: got %0d, expected 15", oe); end
    checks++; if (bd !== 0) begin errors++; $display("FAIL wr_dout: got %0d bad cycles, expected 0", bd); end
    checks++; if (rl !== 0) begin errors++; $display("FAIL wr_romsel: got %0d low cycles, expected 0", rl); end
    checks++; if (bif.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata_held: got %h, expected a5", bif.cpu_rdata); end
    @(posedge CLOCK_50); #1;
    checks++; if (bif.bus_d_oe !== 1'b0) begin errors++; $display("FAIL wr_oe_after: got %b, expected 0", bif.bus_d_oe); end
  endtask

  task automatic test_dbg_then_cpu;
    int ac, who, rl, wl, oe, bd, br, rl0;
    rl0 = 0;
    bif.dbg_addr = 16'hFFFC; bif.dbg_rw = 1; bif.dbg_req = 1;
    repeat (3) begin
      @(posedge CLOCK_50); #1;
      if (!bif.bus_romsel_n) rl0++;
    end
    // CPU arrives during the debug cycle; debug address changes are ignored.
    bif.cpu_addr = 16'h8010; bif.cpu_rw = 1; bif.cpu_req = 1;
    bif.dbg_addr = 16'h0000;
    watch(40, 8'h5A, 8'h00, ac, who, rl, wl, oe, bd, br);
    bif.dbg_req = 0;
    checks++; if (ac !== 17) begin errors++; $display("FAIL dbg_latency: got %0d, expected 17", ac); end
    checks++; if (who !== 2) begin errors++; $display("FAIL dbg_ack_who: got %0d, expected 2", who); end
    checks++; if ((rl + rl0) !== 12) begin errors++; $display("FAIL dbg_romsel_cycles: got %0d, expected 12", rl + rl0); end
    checks++; if (bif.bus_a !== 15'h7FFC) begin errors++; $display("FAIL dbg_bus_a: got %h, expected 7ffc", bif.bus_a); end
    checks++; if (bif.dbg_rdata !== 8'h5A) begin errors++; $display("FAIL dbg_rdata: got %h, expected 5a", bif.dbg_rdata); end
    checks++; if (bif.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL dbg_cpu_rdata_held: got %h, expected a5", bif.cpu_rdata); end
    watch(40, 8'hC3, 8'h00, ac, who, rl, wl, oe, bd, br);
    bif.cpu_req = 0;
    checks++; if (ac !== 21) begin errors++; $display("FAIL cpu_after_dbg_latency: got %0d, expected 21", ac); end
    checks++; if (who !== 1) begin errors++; $display("FAIL cpu_after_dbg_who: got %0d, expected 1", who); end
    checks++; if (bif.cpu_rdata !== 8'hC3) begin errors++; $display("FAIL cpu_after_dbg_rdata: got %h, expected c3", bif.cpu_rdata); end
    checks++; if (bif.bus_a !== 15'h0010) begin errors++; $display("FAIL cpu_after_dbg_bus_a: got %h, expected 0010", bif.bus_a); end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset_mid_cycle;
    int ac, who, rl, wl, oe, bd, br, acks;
    acks = 0;
    bif.cpu_addr = 16'h6000; bif.cpu_rw = 0; bif.cpu_wdata = 8'h77; bif.cpu_req = 1;
    repeat (8) @(posedge CLOCK_50);
    #1;
    checks++;
    if ({bif.bus_m2, bif.bus_d_oe, bif.bus_rw} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid_pre: got m2/oe/rw=%b, expected 110", {bif.bus_m2, bif.bus_d_oe, bif.bus_rw});
    end
    #3 reset = 1;
    #1;
    checks++;
    if ({bif.bus_m2, bif.bus_d_oe, bif.bus_rw, bif.bus_romsel_n, bif.busy, bif.bus_a} !== {5'b00110, 15'h0}) begin
      errors++;
      $display("FAIL rst_mid_pins: got m2/oe/rw/rs/busy=%b a=%h, expected 00110 a=0",
               {bif.bus_m2, bif.bus_d_oe, bif.bus_rw, bif.bus_romsel_n, bif.busy}, bif.bus_a);
    end
    checks++; if (bif.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata: got %h, expected 00", bif.cpu_rdata); end
    repeat (2) begin
      @(posedge CLOCK_50); #1;
      if (bif.cpu_ack || bif.dbg_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d, expected 0", acks); end
    reset = 0;
    watch(40, 8'h00, 8'h77, ac, who, rl, wl, oe, bd, br);
    bif.cpu_req = 0;
    checks++; if (ac !== 20) begin errors++; $display("FAIL rst_reissue_latency: got %0d, expected 20", ac); end
    checks++; if (who !== 1) begin errors++; $display("FAIL rst_reissue_who: got %0d, expected 1", who); end
    checks++; if ({wl, oe} !== {32'd18, 32'd15}) begin errors++; $display("FAIL rst_reissue_rw_oe: got %0d/%0d, expected 18/15", wl, oe); end
    checks++; if (bd !== 0) begin errors++; $display("FAIL rst_reissue_dout: got %0d bad cycles, expected 0", bd); end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_round_robin;
    int seq[4];
    int nack, overlap, ack_hi, idle, bad_a, m2_rise;
    logic m2_prev;
    nack = 0; overlap = 0; ack_hi = 0; idle = 0; bad_a = 0; m2_rise = 0; m2_prev = 0;
    reset = 1;
    bif.cpu_addr = 16'h8010; bif.cpu_rw = 1; bif.cpu_req = 1;
    bif.dbg_addr = 16'h8020; bif.dbg_rw = 1; bif.dbg_req = 1;
    bif.bus_d_in = 8'h00;
    @(posedge CLOCK_50); #1;
    reset = 0;
    for (int n = 0; n < 120 && nack < 4; n++) begin
      @(posedge CLOCK_50); #1;
      if (bif.bus_m2 && !m2_prev) m2_rise++;
      m2_prev = bif.bus_m2;
      if (!bif.busy) idle++;
      if (bif.cpu_ack && bif.dbg_ack) overlap++;
      if (bif.cpu_ack || bif.dbg_ack) begin
        ack_hi++;
        if (bif.bus_a !== (bif.cpu_ack ? 15'h0010 : 15'h0020)) bad_a++;
        seq[nack] = bif.cpu_ack ? 1 : 2;
        nack++;
      end
    end
    bif.cpu_req = 0; bif.dbg_req = 0;
    @(posedge CLOCK_50); #1;
    if (bif.cpu_ack || bif.dbg_ack) ack_hi++;
    checks++; if (nack !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d, expected 4", nack); end
    checks++;
    if ({seq[0], seq[1], seq[2], seq[3]} !== {32'd1, 32'd2, 32'd1, 32'd2}) begin
      errors++;
      $display("FAIL rr_order: got %0d %0d %0d %0d, expected 1 2 1 2", seq[0], seq[1], seq[2], seq[3]);
    end
    checks++; if (ack_hi !== 4) begin errors++; $display("FAIL rr_ack_width: got %0d ack-high cycles, expected 4", ack_hi); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL rr_overlap: got %0d, expected 0", overlap); end
    checks++; if (idle !== 3) begin errors++; $display("FAIL rr_idle_gaps: got %0d, expected 3", idle); end
    checks++; if (bad_a !== 0) begin errors++; $display("FAIL rr_bus_a: got %0d wrong, expected 0", bad_a); end
    checks++; if (m2_rise !== 4) begin errors++; $display("FAIL rr_m2_pulses: got %0d, expected 4", m2_rise); end
  endtask

  task automatic test_short_params;
    int ac, m2cnt;
    ac = 0; m2cnt = 0;
    bif2.cpu_addr = 16'h8000; bif2.cpu_rw = 1; bif2.cpu_req = 1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLOCK_50); #1;
      if (bif2.bus_m2) m2cnt++;
      bif2.bus_d_in = bif2.bus_m2 ? ((m2cnt == 1) ? 8'h11 : 8'h22) : 8'h00;
      if (bif2.cpu_ack) begin
        ac = n + 1;
        break;
      end
    end
    bif2.cpu_req = 0;
    checks++; if (ac !== 6) begin errors++; $display("FAIL short_latency: got %0d, expected 6", ac); end
    checks++; if (m2cnt !== 2) begin errors++; $display("FAIL short_m2_cycles: got %0d, expected 2", m2cnt); end
    checks++; if (bif2.cpu_rdata !== 8'h22) begin errors++; $display("FAIL short_sample: got %h, expected 22", bif2.cpu_rdata); end
    @(posedge CLOCK_50); #1;
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_cpu_write;
    test_dbg_then_cpu;
    test_reset_mid_cycle;
    test_round_robin;
    test_short_params;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
